perf_event_monitor: RTL and testbench
=====================================

Name: perf_event_monitor

Overview:
- Synthesizable, parametrised event-counting monitor attached beside the pipelined processor core.
- Counts per-cycle event strobes over N channels plus a free-running cycle counter. Typical events: retired instruction, I-cache request/hit, D-cache request/hit.
- Freezes and snapshots all counts when the core halts.
- Exposes counts through a registered read port, so hardware reads the statistics instead of a simulation-only bench.

Parameters:
- NUM_EVT, 4, number of event channels (1..16).
- CNT_W, 16, width of every counter, including the cycle counter (4..32).
- SATURATE, 0, overflow mode. 0 = wrap to 0. 1 = hold at all-ones.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  counting enable; when low, counters hold.
- evt  input  NUM_EVT  event strobes; bit i high = one event on channel i this cycle.
- halt  input  1  core halt indication; level, sampled each cycle.
- snap  input  1  software snapshot request, one-cycle pulse.
- clr  input  1  synchronous clear of counters, overflow flags and frozen state.
- rd_sel  input  SEL_W  read select, SEL_W = $clog2(NUM_EVT+1). Values 0..NUM_EVT-1 select an event channel; NUM_EVT selects the cycle counter.
- rd_data  output  CNT_W  registered shadow value of the selected counter.
- rd_ovf  output  1  registered sticky overflow flag of the selected counter.
- frozen  output  1  high once a halt has been captured.
- halt_done  output  1  one-cycle pulse in the cycle after halt is captured.

Behaviour:
- Reset (rst low, asynchronous): all live counters, shadow registers and overflow flags = 0; rd_data = 0, rd_ovf = 0, frozen = 0, halt_done = 0.
- Running condition: active = en & ~frozen.
  - Cycle counter increments by 1 every cycle active is high.
  - Channel i increments by 1 when active & evt[i].
- Overflow: an increment from all-ones sets that counter's sticky ovf flag.
  - SATURATE=0: counter wraps to 0.
  - SATURATE=1: counter stays all-ones.
  - The flag stays set until clr or reset.
- Shadow capture: on a cycle with (snap | (halt & ~frozen)) & ~clr, every shadow register and shadow ovf flag loads the live counter's next-state value.
  - The capture therefore includes any increment occurring in that same cycle.
  - A halt-cycle event is counted, and the halt cycle itself is counted by the cycle counter.
- Halt: the first cycle with halt high while frozen = 0:
  - frozen <= 1 next edge; halt_done <= 1 for exactly one cycle.
  - Further halt cycles have no effect; no extra halt_done pulse.
  - While frozen, live counters hold, snap still re-captures (identical values).
- Clear: clr has highest priority.
  - Live counters, shadows, ovf flags and frozen <= 0; no increment that cycle.
  - halt & clr in the same cycle: halt ignored, no halt_done.
  - snap & clr in the same cycle: shadows are 0.
- Read port: rd_data/rd_ovf <= shadow[rd_sel] each cycle, so read latency is 1 cycle.
  - rd_sel > NUM_EVT returns 0 / 0.
  - Live counters are never read directly; software must snap first.
- en low: counters hold; snap, halt capture and clr still operate normally.
- Width rules: all arithmetic is unsigned CNT_W; there are no carries between counters.

Test Plan:
- Reset and count (NUM_EVT=4, CNT_W=16):
  - Stimulus: release rst, en=1; evt=4'b0011 for 10 cycles, then 4'b0100 for 5 cycles; snap.
  - Required: read ch0=10, ch1=10, ch2=5, ch3=0, cycle=16 (15 event cycles + the snap cycle), ovf=0; each read valid 1 cycle after rd_sel.
- Halt freeze:
  - Stimulus: evt[0]=1 every cycle; assert halt at cycle 20 and hold it for 5 cycles.
  - Required: halt_done high exactly 1 cycle; frozen=1; ch0=21, cycle=21; values unchanged after 10 more cycles with evt active.
- Overflow wrap (CNT_W=4, SATURATE=0):
  - Stimulus: 17 evt[1] pulses, then snap.
  - Required: ch1=1, rd_ovf=1.
- Overflow saturate (CNT_W=4, SATURATE=1):
  - Stimulus: same 17 pulses, then snap.
  - Required: ch1=15, rd_ovf=1.
- Priority:
  - Stimulus: clr together with halt, snap and evt=4'b1111.
  - Required: all reads 0, frozen=0, no halt_done. Next-cycle halt then freezes normally with cycle=1.
- Asynchronous reset mid-run:
  - Stimulus: drop rst between clock edges while counters are nonzero and frozen=1.
  - Required: rd_data, frozen and halt_done go to 0 immediately without a clock; counting restarts from 0 after release.
- en gating:
  - Stimulus: en=0 for 8 cycles with evt=4'b1111, then snap.
  - Required: all counts, including cycle, unchanged from before en dropped.

Source files
------------

// File: rtl/perf_event_monitor.sv
// Event-counting performance monitor: NUM_EVT event channels plus a cycle counter,
// frozen and snapshotted on core halt, read back through a registered shadow port.
module perf_event_monitor #(
  parameter int NUM_EVT = 4,
  parameter int CNT_W = 16,
  parameter bit SATURATE = 1'b0,
  localparam int SEL_W = $clog2(NUM_EVT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NUM_EVT-1:0] evt,
  input  logic             halt,
  input  logic             snap,
  input  logic             clr,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_ovf,
  output logic             frozen,
  output logic             halt_done
);

  localparam int NCNT = NUM_EVT + 1;
  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  logic [CNT_W-1:0] liveCnt   [NCNT];
  logic [CNT_W-1:0] cntNext   [NCNT];
  logic [CNT_W-1:0] shadowCnt [NCNT];
  logic [NCNT-1:0]  liveOvf;
  logic [NCNT-1:0]  ovfNext;
  logic [NCNT-1:0]  shadowOvf;
  logic [NCNT-1:0]  incMask;
  logic             active;
  logic             capture;
  logic             haltCapture;
  logic [CNT_W-1:0] selData;
  logic             selOvf;

  // The top bit of incMask is the cycle counter, which counts every active cycle.
  assign incMask     = {1'b1, evt};
  assign active      = en & ~frozen & ~clr;
  assign haltCapture = halt & ~frozen & ~clr;
  assign capture     = (snap | (halt & ~frozen)) & ~clr;

  always_comb begin
    for (int j = 0; j < NCNT; j++) begin
      cntNext[j] = liveCnt[j];
      ovfNext[j] = liveOvf[j];
      if (clr) begin
        cntNext[j] = '0;
        ovfNext[j] = 1'b0;
      end else if (active && incMask[j]) begin
        if (liveCnt[j] == ALL_ONES) begin
          ovfNext[j] = 1'b1;
          cntNext[j] = SATURATE ? ALL_ONES : '0;
        end else begin
          cntNext[j] = liveCnt[j] + CNT_W'(1);
        end
      end
    end
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    selData = '0;
    selOvf  = 1'b0;
    for (int j = 0; j < NCNT; j++) begin
      if (rd_sel == SEL_W'(j)) begin
        selData = shadowCnt[j];
        selOvf  = shadowOvf[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < NCNT; j++) begin
        liveCnt[j]   <= '0;
        shadowCnt[j] <= '0;
      end
      liveOvf   <= '0;
      shadowOvf <= '0;
      frozen    <= 1'b0;
      halt_done <= 1'b0;
      rd_data   <= '0;
      rd_ovf    <= 1'b0;
    end else begin
      liveCnt <= cntNext;
      liveOvf <= ovfNext;
      // Shadows take next-state values so a same-cycle increment is included.
      if (capture || clr) begin
        shadowCnt <= cntNext;
        shadowOvf <= ovfNext;
      end
      if (clr) begin
        frozen <= 1'b0;
      end else if (halt) begin
        frozen <= 1'b1;
      end
      halt_done <= haltCapture;
      rd_data   <= selData;
      rd_ovf    <= selOvf;
    end
  end

endmodule

// File: tb/tb_perf_event_monitor.sv
// Directed bench for perf_event_monitor: a 16-bit main instance plus 4-bit wrap
// and saturate instances sharing the same stimulus.
module tb_perf_event_monitor;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] expData;
    logic        expOvf;
  } readVec_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  evt;
  logic        halt;
  logic        snap;
  logic        clr;
  logic [2:0]  rd_sel;
  logic [15:0] rdData;
  logic        rdOvf;
  logic        frozen;
  logic        haltDone;
  logic [3:0]  rdDataW;
  logic        rdOvfW;
  logic        frozenW;
  logic        haltDoneW;
  logic [3:0]  rdDataS;
  logic        rdOvfS;
  logic        frozenS;
  logic        haltDoneS;

  int checks = 0;
  int errors = 0;
  int pulses;
  readVec_t vecs[$];

  perf_event_monitor #(.NUM_EVT(4), .CNT_W(16), .SATURATE(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .evt(evt), .halt(halt), .snap(snap), .clr(clr),
    .rd_sel(rd_sel), .rd_data(rdData), .rd_ovf(rdOvf), .frozen(frozen), .halt_done(haltDone)
  );

  perf_event_monitor #(.NUM_EVT(4), .CNT_W(4), .SATURATE(1'b0)) dutWrap (
    .clk(clk), .rst(rst), .en(en), .evt(evt), .halt(halt), .snap(snap), .clr(clr),
    .rd_sel(rd_sel), .rd_data(rdDataW), .rd_ovf(rdOvfW), .frozen(frozenW), .halt_done(haltDoneW)
  );

  perf_event_monitor #(.NUM_EVT(4), .CNT_W(4), .SATURATE(1'b1)) dutSat (
    .clk(clk), .rst(rst), .en(en), .evt(evt), .halt(halt), .snap(snap), .clr(clr),
    .rd_sel(rd_sel), .rd_data(rdDataS), .rd_ovf(rdOvfS), .frozen(frozenS), .halt_done(haltDoneS)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Select a counter and wait the one cycle of read latency.
  task automatic applyStimulus(input logic [2:0] sel);
    rd_sel = sel;
    stepClk();
  endtask

  task automatic runVectors(input string label);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].sel);
      checkOutput($sformatf("%s data sel%0d", label, vecs[i].sel), 32'(rdData), vecs[i].expData);
      checkOutput($sformatf("%s ovf sel%0d", label, vecs[i].sel), 32'(rdOvf), 32'(vecs[i].expOvf));
    end
    vecs.delete();
  endtask

  task automatic addVec(input logic [2:0] sel, input logic [31:0] expData, input logic expOvf);
    readVec_t v;
    v.sel = sel;
    v.expData = expData;
    v.expOvf = expOvf;
    vecs.push_back(v);
  endtask

  task automatic clearAll();
    en = 1'b0; evt = 4'b0; halt = 1'b0; snap = 1'b0; clr = 1'b1;
    stepClk();
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; evt = 4'b0; halt = 1'b0; snap = 1'b0; clr = 1'b0; rd_sel = 3'd0;
    #1;
    checkOutput("reset rd_data", 32'(rdData), 32'd0);
    checkOutput("reset rd_ovf", 32'(rdOvf), 32'd0);
    checkOutput("reset frozen", 32'(frozen), 32'd0);
    checkOutput("reset halt_done", 32'(haltDone), 32'd0);
    stepClk();
    stepClk();
    rst = 1'b1;

    // Basic counting: 10 cycles of 0011, 5 of 0100, then a snap cycle.
    en = 1'b1; evt = 4'b0011;
    for (int i = 0; i < 10; i++) stepClk();
    evt = 4'b0100;
    for (int i = 0; i < 5; i++) stepClk();
    evt = 4'b0000; snap = 1'b1;
    stepClk();
    snap = 1'b0; en = 1'b0;
    addVec(3'd0, 10, 1'b0);
    addVec(3'd1, 10, 1'b0);
    addVec(3'd2, 5, 1'b0);
    addVec(3'd3, 0, 1'b0);
    addVec(3'd4, 16, 1'b0);
    addVec(3'd7, 0, 1'b0);
    runVectors("count");

    // Overflow: 17 pulses on channel 1 across all three instances.
    clearAll();
    en = 1'b1; evt = 4'b0010;
    for (int i = 0; i < 17; i++) stepClk();
    en = 1'b0; evt = 4'b0000; snap = 1'b1;
    stepClk();
    snap = 1'b0;
    applyStimulus(3'd1);
    checkOutput("ovf main data", 32'(rdData), 32'd17);
    checkOutput("ovf main flag", 32'(rdOvf), 32'd0);
    checkOutput("ovf wrap data", 32'(rdDataW), 32'd1);
    checkOutput("ovf wrap flag", 32'(rdOvfW), 32'd1);
    checkOutput("ovf sat data", 32'(rdDataS), 32'd15);
    checkOutput("ovf sat flag", 32'(rdOvfS), 32'd1);
    applyStimulus(3'd0);
    checkOutput("ovf wrap ch0 flag", 32'(rdOvfW), 32'd0);
    applyStimulus(3'd4);
    checkOutput("ovf wrap cycle data", 32'(rdDataW), 32'd1);
    checkOutput("ovf sat cycle data", 32'(rdDataS), 32'd15);
    checkOutput("ovf sat cycle flag", 32'(rdOvfS), 32'd1);
    clearAll();
    snap = 1'b1;
    stepClk();
    snap = 1'b0;
    applyStimulus(3'd1);
    checkOutput("ovf cleared wrap flag", 32'(rdOvfW), 32'd0);
    checkOutput("ovf cleared sat flag", 32'(rdOvfS), 32'd0);
    checkOutput("ovf cleared sat data", 32'(rdDataS), 32'd0);

    // Halt freeze: 20 event cycles, then halt held for 5 cycles.
    clearAll();
    en = 1'b1; evt = 4'b0001;
    for (int i = 0; i < 20; i++) stepClk();
    halt = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      stepClk();
      if (haltDone) pulses++;
      checkOutput($sformatf("halt frozen step%0d", i), 32'(frozen), 32'd1);
    end
    checkOutput("halt_done pulse count", 32'(pulses), 32'd1);
    halt = 1'b0;
    for (int i = 0; i < 10; i++) stepClk();
    addVec(3'd0, 21, 1'b0);
    addVec(3'd4, 21, 1'b0);
    runVectors("halt");
    snap = 1'b1;
    stepClk();
    snap = 1'b0;
    addVec(3'd0, 21, 1'b0);
    addVec(3'd4, 21, 1'b0);
    runVectors("halt resnap");

    // Priority: clr with halt, snap and all events; halt the very next cycle.
    rd_sel = 3'd0;
    clr = 1'b1; halt = 1'b1; snap = 1'b1; evt = 4'b1111; en = 1'b1;
    stepClk();
    checkOutput("prio frozen", 32'(frozen), 32'd0);
    checkOutput("prio halt_done", 32'(haltDone), 32'd0);
    clr = 1'b0; snap = 1'b0; evt = 4'b0000; halt = 1'b1;
    stepClk();
    checkOutput("prio shadow after clr", 32'(rdData), 32'd0);
    checkOutput("prio refreeze", 32'(frozen), 32'd1);
    checkOutput("prio refreeze halt_done", 32'(haltDone), 32'd1);
    halt = 1'b0; en = 1'b0;
    addVec(3'd0, 0, 1'b0);
    addVec(3'd1, 0, 1'b0);
    addVec(3'd2, 0, 1'b0);
    addVec(3'd3, 0, 1'b0);
    addVec(3'd4, 1, 1'b0);
    runVectors("prio");

    // en gating: 3 counted cycles, then 8 gated cycles, then snap.
    clearAll();
    en = 1'b1; evt = 4'b1111;
    for (int i = 0; i < 3; i++) stepClk();
    en = 1'b0;
    for (int i = 0; i < 8; i++) stepClk();
    snap = 1'b1;
    stepClk();
    snap = 1'b0;
    for (int i = 0; i < 5; i++) addVec(3'(i), 3, 1'b0);
    runVectors("gate");

    // Asynchronous reset while frozen with nonzero read data.
    evt = 4'b0000;
    applyStimulus(3'd4);
    halt = 1'b1;
    stepClk();
    checkOutput("pre-reset rd_data", 32'(rdData), 32'd3);
    checkOutput("pre-reset frozen", 32'(frozen), 32'd1);
    checkOutput("pre-reset halt_done", 32'(haltDone), 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("async rd_data", 32'(rdData), 32'd0);
    checkOutput("async frozen", 32'(frozen), 32'd0);
    checkOutput("async halt_done", 32'(haltDone), 32'd0);
    halt = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1; evt = 4'b0001;
    for (int i = 0; i < 4; i++) stepClk();
    en = 1'b0; evt = 4'b0000; snap = 1'b1;
    stepClk();
    snap = 1'b0;
    addVec(3'd0, 4, 1'b0);
    addVec(3'd1, 0, 1'b0);
    addVec(3'd4, 4, 1'b0);
    runVectors("restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
